// File: rtl/rca_loop_profiler_pkg.sv
// Shared configuration for the RCA hot-loop profiler: default sizes, table entry
// layout and scan FSM state encoding.
package rca_config;

    localparam int unsigned RCA_XLEN           = 32;
    localparam int unsigned NUM_PROF_ENTRIES   = 8;
    localparam int unsigned PROF_COUNT_W       = 16;
    localparam int unsigned PROF_HOT_THRESHOLD = 64;
    localparam int unsigned PROF_DECAY_PERIOD  = 4096;

    // One profiler table entry: loop start (branch target), loop end (branch pc).
    typedef struct packed {
        logic [RCA_XLEN-1:0]     start_addr;
        logic [RCA_XLEN-1:0]     end_addr;
        logic [PROF_COUNT_W-1:0] count;
        logic                    valid;
    } prof_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } prof_scan_state_t;

endpackage

// File: rtl/rca_loop_profiler_victim_sel.sv
// Miss-allocation victim picker: lowest-index invalid entry, otherwise the
// lowest-index entry holding the minimum count.
module rca_prof_victim_sel #(
    parameter int unsigned NUM_ENTRIES = 8,
    parameter int unsigned COUNT_W     = 16,
    parameter int unsigned IDX_W       = 3
) (
    input  logic [NUM_ENTRIES-1:0] valid,
    input  logic [COUNT_W-1:0]     count [NUM_ENTRIES],
    output logic [IDX_W-1:0]       victim_idx_c
);

    logic               inv_found;
    logic [IDX_W-1:0]   inv_idx;
    logic [IDX_W-1:0]   min_idx;
    logic [COUNT_W-1:0] min_cnt;

    // Priority search: descending walk leaves the lowest invalid index, strict
    // less-than keeps the lowest index among equal minimum counts.
    always_comb begin
        inv_found = 1'b0;
        inv_idx   = '0;
        for (int i = int'(NUM_ENTRIES) - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                inv_found = 1'b1;
                inv_idx   = IDX_W'(i);
            end
        end
        min_idx = '0;
        min_cnt = count[0];
        for (int i = 1; i < int'(NUM_ENTRIES); i++) begin
            if (count[i] < min_cnt) begin
                min_cnt = count[i];
                min_idx = IDX_W'(i);
            end
        end
        victim_idx_c = inv_found ? inv_idx : min_idx;
    end

endmodule

// File: rtl/rca_loop_profiler.sv
// Hot-loop profiler: counts taken backward branches in a small fully-associative
// table and, on query, scans it one entry per cycle to report the hottest loop.
// Optional periodic count halving is enabled by defining RCA_PROF_DECAY_EN.
module rca_loop_profiler
    import rca_config::*;
#(
    parameter int unsigned XLEN          = RCA_XLEN,
    parameter int unsigned NUM_ENTRIES   = NUM_PROF_ENTRIES,
    parameter int unsigned COUNT_W       = PROF_COUNT_W,
    parameter int unsigned HOT_THRESHOLD = PROF_HOT_THRESHOLD
`ifdef RCA_PROF_DECAY_EN
    ,
    parameter int unsigned DECAY_PERIOD  = PROF_DECAY_PERIOD
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               br_valid,
    input  logic               br_taken,
    input  logic [XLEN-1:0]    br_pc,
    input  logic [XLEN-1:0]    br_target,
    input  logic               prof_en,
    input  logic               prof_clear,
    input  logic               query_valid,
    output logic               query_ready,
    output logic               result_valid,
    output logic               result_hit,
    output logic [XLEN-1:0]    result_start,
    output logic [XLEN-1:0]    result_end,
    output logic [COUNT_W-1:0] result_count
);

    localparam int unsigned      IDX_W    = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
    localparam logic [COUNT_W-1:0] CNT_MAX = '1;
    localparam logic [COUNT_W-1:0] HOT_TH  = COUNT_W'(HOT_THRESHOLD);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

    // Profiler table
    logic [NUM_ENTRIES-1:0] ent_valid,   ent_valid_n;
    logic [XLEN-1:0]        ent_start    [NUM_ENTRIES];
    logic [XLEN-1:0]        ent_start_n  [NUM_ENTRIES];
    logic [XLEN-1:0]        ent_end      [NUM_ENTRIES];
    logic [XLEN-1:0]        ent_end_n    [NUM_ENTRIES];
    logic [COUNT_W-1:0]     ent_count    [NUM_ENTRIES];
    logic [COUNT_W-1:0]     ent_count_n  [NUM_ENTRIES];

    logic               cand_c;
    logic               hit_c;
    logic [IDX_W-1:0]   hit_idx_c;
    logic [IDX_W-1:0]   victim_idx_c;
    logic               do_decay_c;

    // Scan FSM
    prof_scan_state_t   state, state_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic               best_valid, best_valid_n;
    logic [XLEN-1:0]    best_start, best_start_n;
    logic [XLEN-1:0]    best_end, best_end_n;
    logic [COUNT_W-1:0] best_count, best_count_n;
    logic               res_valid_n, res_hit_n, fin_hit;
    logic [XLEN-1:0]    res_start_n, res_end_n;
    logic [COUNT_W-1:0] res_count_n;

    // Candidate loop: taken strictly-backward branch while profiling is on.
    assign cand_c = br_valid & br_taken & prof_en & (br_target < br_pc);

    // Associative match on (start, end); allocation on miss keeps matches unique.
    always_comb begin
        hit_c     = 1'b0;
        hit_idx_c = '0;
        for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
            if (ent_valid[i] && (ent_start[i] == br_target) && (ent_end[i] == br_pc)) begin
                hit_c     = 1'b1;
                hit_idx_c = IDX_W'(i);
            end
        end
    end

    rca_prof_victim_sel #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .COUNT_W     (COUNT_W),
        .IDX_W       (IDX_W)
    ) u_victim_sel (
        .valid        (ent_valid),
        .count        (ent_count),
        .victim_idx_c (victim_idx_c)
    );

`ifdef RCA_PROF_DECAY_EN
    localparam int unsigned       DCNT_W    = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DECAY_PERIOD - 1);

    logic [DCNT_W-1:0] decay_cnt;
    logic              decay_pend;
    logic              decay_wrap_c;

    assign decay_wrap_c = cand_c & ~prof_clear & (decay_cnt == DCNT_LAST);
    // Halving only happens while the scanner is idle; otherwise it waits.
    assign do_decay_c   = (decay_wrap_c | decay_pend) & (state == IDLE);

    // Event period counter and deferred-decay flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            decay_cnt  <= '0;
            decay_pend <= 1'b0;
        end else begin
            if (cand_c && !prof_clear) begin
                decay_cnt <= decay_wrap_c ? '0 : decay_cnt + DCNT_W'(1);
            end
            decay_pend <= ~prof_clear & (decay_wrap_c | decay_pend) & (state != IDLE);
        end
    end
`else
    assign do_decay_c = 1'b0;
`endif

    // Next table state: clear wins, then decay, then the hit/allocate update.
    always_comb begin
        ent_valid_n = ent_valid;
        ent_start_n = ent_start;
        ent_end_n   = ent_end;
        ent_count_n = ent_count;
        if (prof_clear) begin
            ent_valid_n = '0;
        end else begin
            if (do_decay_c) begin
                for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
                    ent_count_n[i] = ent_count[i] >> 1;
                    if (ent_count_n[i] == '0) begin
                        ent_valid_n[i] = 1'b0;
                    end
                end
            end
            if (cand_c) begin
                if (hit_c) begin
                    if (ent_count_n[hit_idx_c] != CNT_MAX) begin
                        ent_count_n[hit_idx_c] = ent_count_n[hit_idx_c] + COUNT_W'(1);
                    end
                    ent_valid_n[hit_idx_c] = 1'b1;
                end else begin
                    ent_valid_n[victim_idx_c] = 1'b1;
                    ent_start_n[victim_idx_c] = br_target;
                    ent_end_n[victim_idx_c]   = br_pc;
                    ent_count_n[victim_idx_c] = COUNT_W'(1);
                end
            end
        end
    end

    // Table registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ent_valid <= '0;
            for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
                ent_start[i] <= '0;
                ent_end[i]   <= '0;
                ent_count[i] <= '0;
            end
        end else begin
            ent_valid <= ent_valid_n;
            ent_start <= ent_start_n;
            ent_end   <= ent_end_n;
            ent_count <= ent_count_n;
        end
    end

    // Scan FSM next state and result computation; reads the live table.
    always_comb begin
        state_n      = state;
        idx_n        = idx;
        best_valid_n = best_valid;
        best_start_n = best_start;
        best_end_n   = best_end;
        best_count_n = best_count;
        res_valid_n  = 1'b0;
        res_hit_n    = result_hit;
        res_start_n  = result_start;
        res_end_n    = result_end;
        res_count_n  = result_count;
        fin_hit      = 1'b0;
        unique case (state)
            IDLE: begin
                if (query_valid) begin
                    state_n      = SCAN;
                    idx_n        = '0;
                    best_valid_n = 1'b0;
                    best_start_n = '0;
                    best_end_n   = '0;
                    best_count_n = '0;
                end
            end
            SCAN: begin
                if (prof_clear) begin
                    state_n     = DONE;
                    res_valid_n = 1'b1;
                    res_hit_n   = 1'b0;
                    res_start_n = '0;
                    res_end_n   = '0;
                    res_count_n = '0;
                end else begin
                    if (ent_valid[idx] && (ent_count[idx] > best_count)) begin
                        best_valid_n = 1'b1;
                        best_start_n = ent_start[idx];
                        best_end_n   = ent_end[idx];
                        best_count_n = ent_count[idx];
                    end
                    if (idx == LAST_IDX) begin
                        fin_hit     = best_valid_n && (best_count_n >= HOT_TH);
                        state_n     = DONE;
                        res_valid_n = 1'b1;
                        res_hit_n   = fin_hit;
                        res_start_n = fin_hit ? best_start_n : '0;
                        res_end_n   = fin_hit ? best_end_n   : '0;
                        res_count_n = fin_hit ? best_count_n : '0;
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Scan FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            best_valid   <= 1'b0;
            best_start   <= '0;
            best_end     <= '0;
            best_count   <= '0;
            query_ready  <= 1'b1;
            result_valid <= 1'b0;
            result_hit   <= 1'b0;
            result_start <= '0;
            result_end   <= '0;
            result_count <= '0;
        end else begin
            state        <= state_n;
            idx          <= idx_n;
            best_valid   <= best_valid_n;
            best_start   <= best_start_n;
            best_end     <= best_end_n;
            best_count   <= best_count_n;
            query_ready  <= (state_n == IDLE);
            result_valid <= res_valid_n;
            result_hit   <= res_hit_n;
            result_start <= res_start_n;
            result_end   <= res_end_n;
            result_count <= res_count_n;
        end
    end

endmodule

// File: tb/tb_rca_loop_profiler.sv
// Scoreboard bench for rca_loop_profiler: a default instance, a 4-bit-counter
// instance with a low threshold, and (with RCA_PROF_DECAY_EN) a decay instance.
module tb_rca_loop_profiler;

    localparam int LAT = 9;

    typedef struct {
        bit          hit;
        logic [31:0] st;
        logic [31:0] en;
        logic [31:0] cnt;
        int          cyc;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rst_dec;
    logic        br_valid, br_taken, prof_en, prof_clear, query_valid;
    logic [31:0] br_pc, br_target;

    logic        query_ready, result_valid, result_hit;
    logic [31:0] result_start, result_end;
    logic [15:0] result_count;

    logic        s_ready, s_valid, s_hit;
    logic [31:0] s_start, s_end;
    logic [3:0]  s_count;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    exp_t exp_q[$];
    exp_t sat_q[$];
    exp_t dec_q[$];
    exp_t sat_e, dec_e, m_e, ms_e, md_e;
    bit   sat_arm = 1'b0;
    bit   dec_arm = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rca_loop_profiler u_dut (
        .clk(clk), .rst(rst), .br_valid(br_valid), .br_taken(br_taken),
        .br_pc(br_pc), .br_target(br_target), .prof_en(prof_en), .prof_clear(prof_clear),
        .query_valid(query_valid), .query_ready(query_ready), .result_valid(result_valid),
        .result_hit(result_hit), .result_start(result_start), .result_end(result_end),
        .result_count(result_count)
    );

    rca_loop_profiler #(.COUNT_W(4), .HOT_THRESHOLD(4)) u_sat (
        .clk(clk), .rst(rst), .br_valid(br_valid), .br_taken(br_taken),
        .br_pc(br_pc), .br_target(br_target), .prof_en(prof_en), .prof_clear(prof_clear),
        .query_valid(query_valid), .query_ready(s_ready), .result_valid(s_valid),
        .result_hit(s_hit), .result_start(s_start), .result_end(s_end),
        .result_count(s_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

`ifdef RCA_PROF_DECAY_EN
    logic        d_ready, d_valid, d_hit;
    logic [31:0] d_start, d_end;
    logic [15:0] d_count;
    logic        rst_d;
    assign rst_d = rst | rst_dec;

    rca_loop_profiler #(.HOT_THRESHOLD(4), .DECAY_PERIOD(16)) u_dec (
        .clk(clk), .rst(rst_d), .br_valid(br_valid), .br_taken(br_taken),
        .br_pc(br_pc), .br_target(br_target), .prof_en(prof_en), .prof_clear(prof_clear),
        .query_valid(query_valid), .query_ready(d_ready), .result_valid(d_valid),
        .result_hit(d_hit), .result_start(d_start), .result_end(d_end),
        .result_count(d_count)
    );

    // Decay-instance monitor: checks only armed queries.
    always @(negedge clk) begin
        if (d_valid === 1'b1 && dec_q.size() > 0) begin
            md_e = dec_q.pop_front();
            chk({md_e.tag, "_dec_hit"},   64'(d_hit),   64'(md_e.hit));
            chk({md_e.tag, "_dec_start"}, 64'(d_start), 64'(md_e.st));
            chk({md_e.tag, "_dec_end"},   64'(d_end),   64'(md_e.en));
            chk({md_e.tag, "_dec_count"}, 64'(d_count), 64'(md_e.cnt));
            chk({md_e.tag, "_dec_cycle"}, 64'(cyc),     64'(md_e.cyc));
        end
    end
`endif

    // Main monitor: every result pulse must match the next expectation.
    always @(negedge clk) begin
        if (result_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_result: result_valid=1 at cycle %0d, want 0", cyc);
            end else begin
                m_e = exp_q.pop_front();
                chk({m_e.tag, "_hit"},   64'(result_hit),   64'(m_e.hit));
                chk({m_e.tag, "_start"}, 64'(result_start), 64'(m_e.st));
                chk({m_e.tag, "_end"},   64'(result_end),   64'(m_e.en));
                chk({m_e.tag, "_count"}, 64'(result_count), 64'(m_e.cnt));
                chk({m_e.tag, "_cycle"}, 64'(cyc),          64'(m_e.cyc));
            end
        end
    end

    // Small-counter instance monitor: checks only armed queries.
    always @(negedge clk) begin
        if (s_valid === 1'b1 && sat_q.size() > 0) begin
            ms_e = sat_q.pop_front();
            chk({ms_e.tag, "_sat_hit"},   64'(s_hit),   64'(ms_e.hit));
            chk({ms_e.tag, "_sat_start"}, 64'(s_start), 64'(ms_e.st));
            chk({ms_e.tag, "_sat_end"},   64'(s_end),   64'(ms_e.en));
            chk({ms_e.tag, "_sat_count"}, 64'(s_count), 64'(ms_e.cnt));
            chk({ms_e.tag, "_sat_cycle"}, 64'(cyc),     64'(ms_e.cyc));
        end
    end

    task automatic send(input logic [31:0] pc, input logic [31:0] tgt, input bit taken,
                        input bit en, input int n);
        for (int i = 0; i < n; i++) begin
            br_valid  = 1'b1;
            br_taken  = taken;
            prof_en   = en;
            br_pc     = pc;
            br_target = tgt;
            @(negedge clk);
        end
        br_valid = 1'b0;
        br_taken = 1'b0;
        prof_en  = 1'b1;
    endtask

    task automatic clear_tbl();
        prof_clear = 1'b1;
        @(negedge clk);
        prof_clear = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int w = 0;
        while (query_ready !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (query_ready !== 1'b1) chk({tag, "_ready_timeout"}, 64'(query_ready), 64'(1));
    endtask

    task automatic wait_drain(input string tag);
        int w = 0;
        while ((exp_q.size() + sat_q.size() + dec_q.size()) != 0 && w < 30) begin
            @(negedge clk);
            w++;
        end
        if ((exp_q.size() + sat_q.size() + dec_q.size()) != 0) begin
            chk({tag, "_result_timeout"}, 64'(exp_q.size() + sat_q.size() + dec_q.size()), 64'(0));
            exp_q.delete();
            sat_q.delete();
            dec_q.delete();
        end
    endtask

    task automatic set_sat(input bit hit, input logic [31:0] st, input logic [31:0] en,
                           input logic [31:0] cnt);
        sat_e.hit = hit; sat_e.st = st; sat_e.en = en; sat_e.cnt = cnt;
        sat_arm = 1'b1;
    endtask

    task automatic set_dec(input bit hit, input logic [31:0] st, input logic [31:0] en,
                           input logic [31:0] cnt);
        dec_e.hit = hit; dec_e.st = st; dec_e.en = en; dec_e.cnt = cnt;
        dec_arm = 1'b1;
    endtask

    task automatic do_query(input string tag, input bit hit, input logic [31:0] st,
                            input logic [31:0] en, input logic [31:0] cnt);
        exp_t e;
        wait_ready(tag);
        e.hit = hit; e.st = st; e.en = en; e.cnt = cnt; e.cyc = cyc + LAT; e.tag = tag;
        exp_q.push_back(e);
        if (sat_arm) begin
            sat_e.cyc = cyc + LAT; sat_e.tag = tag;
            sat_q.push_back(sat_e);
        end
        if (dec_arm) begin
            dec_e.cyc = cyc + LAT; dec_e.tag = tag;
            dec_q.push_back(dec_e);
        end
        query_valid = 1'b1;
        @(negedge clk);
        query_valid = 1'b0;
        wait_drain(tag);
        sat_arm = 1'b0;
        dec_arm = 1'b0;
    endtask

    initial begin
        exp_t e;
        rst = 1'b1; rst_dec = 1'b0;
        br_valid = 1'b0; br_taken = 1'b0; prof_en = 1'b1; prof_clear = 1'b0;
        query_valid = 1'b0; br_pc = '0; br_target = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_query_ready",  64'(query_ready),  64'(1));
        chk("rst_result_valid", 64'(result_valid), 64'(0));
        chk("rst_result_hit",   64'(result_hit),   64'(0));
        chk("rst_result_start", 64'(result_start), 64'(0));
        chk("rst_result_count", 64'(result_count), 64'(0));

        // One loop: below threshold after 10, hot after 70
        send(32'h1040, 32'h1000, 1'b1, 1'b1, 10);
        do_query("loop10", 1'b0, 32'h0, 32'h0, 32'd0);
        send(32'h1040, 32'h1000, 1'b1, 1'b1, 60);
        do_query("loop70", 1'b1, 32'h1000, 32'h1040, 32'd70);

        // Filtering: forward, not-taken, disabled, self-loop never allocate
        clear_tbl();
        send(32'h1000, 32'h1100, 1'b1, 1'b1, 70);
        send(32'h1040, 32'h1000, 1'b0, 1'b1, 70);
        send(32'h1040, 32'h1000, 1'b1, 1'b0, 70);
        send(32'h1200, 32'h1200, 1'b1, 1'b1, 70);
        do_query("filter", 1'b0, 32'h0, 32'h0, 32'd0);

        // Eviction: loop k gets k+1 events, then a new loop replaces entry 0
        clear_tbl();
        for (int k = 0; k < 8; k++)
            send(32'h4080 + 32'(k) * 32'h100, 32'h4000 + 32'(k) * 32'h100, 1'b1, 1'b1, k + 1);
        send(32'h2080, 32'h2000, 1'b1, 1'b1, 1);
        set_sat(1'b1, 32'h4700, 32'h4780, 32'd8);
        do_query("evict_a", 1'b0, 32'h0, 32'h0, 32'd0);
        // loop 0 was evicted: it re-allocates over the count-1 entry and reaches 10, not 11
        send(32'h4080, 32'h4000, 1'b1, 1'b1, 10);
        set_sat(1'b1, 32'h4000, 32'h4080, 32'd10);
        do_query("evict_b", 1'b0, 32'h0, 32'h0, 32'd0);

        // Saturation on the 4-bit counter instance
        clear_tbl();
        send(32'h5040, 32'h5000, 1'b1, 1'b1, 20);
        set_sat(1'b1, 32'h5000, 32'h5040, 32'd15);
        do_query("sat", 1'b0, 32'h0, 32'h0, 32'd0);

        // Threshold boundary 63/64, then tie and overtake
        clear_tbl();
        send(32'h6040, 32'h6000, 1'b1, 1'b1, 63);
        do_query("thr63", 1'b0, 32'h0, 32'h0, 32'd0);
        send(32'h6040, 32'h6000, 1'b1, 1'b1, 1);
        do_query("thr64", 1'b1, 32'h6000, 32'h6040, 32'd64);
        send(32'h7040, 32'h7000, 1'b1, 1'b1, 64);
        do_query("tie", 1'b1, 32'h6000, 32'h6040, 32'd64);
        send(32'h7040, 32'h7000, 1'b1, 1'b1, 1);
        do_query("overtake", 1'b1, 32'h7000, 32'h7040, 32'd65);

        // prof_clear two cycles into the scan aborts with hit=0 the next cycle
        wait_ready("abort");
        e.hit = 1'b0; e.st = '0; e.en = '0; e.cnt = '0; e.cyc = cyc + 3; e.tag = "abort";
        exp_q.push_back(e);
        query_valid = 1'b1;
        @(negedge clk);
        query_valid = 1'b0;
        @(negedge clk);
        prof_clear = 1'b1;
        @(negedge clk);
        prof_clear = 1'b0;
        wait_drain("abort");
        do_query("after_clear", 1'b0, 32'h0, 32'h0, 32'd0);

        // rst mid-scan: no result pulse, ready again right after reset, table empty
        send(32'h1040, 32'h1000, 1'b1, 1'b1, 70);
        wait_ready("rstscan");
        query_valid = 1'b1;
        @(negedge clk);
        query_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstscan_ready", 64'(query_ready), 64'(1));
        repeat (12) @(negedge clk);
        do_query("after_rst", 1'b0, 32'h0, 32'h0, 32'd0);

`ifdef RCA_PROF_DECAY_EN
        // Decay period 16: the 16th hit lands on the halved count
        clear_tbl();
        rst_dec = 1'b1;
        @(negedge clk);
        rst_dec = 1'b0;
        send(32'h8040, 32'h8000, 1'b1, 1'b1, 16);
        set_dec(1'b1, 32'h8000, 32'h8040, 32'd8);
        do_query("decay16", 1'b0, 32'h0, 32'h0, 32'd0);
        // A count-1 neighbour is dropped while the hot loop becomes (14>>1)+1
        clear_tbl();
        rst_dec = 1'b1;
        @(negedge clk);
        rst_dec = 1'b0;
        send(32'h9040, 32'h9000, 1'b1, 1'b1, 1);
        send(32'h8040, 32'h8000, 1'b1, 1'b1, 15);
        set_dec(1'b1, 32'h8000, 32'h8040, 32'd8);
        do_query("decay_mix", 1'b0, 32'h0, 32'h0, 32'd0);
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time bound
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at cycle %0d, want finished", cyc);
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
